// File: rtl/rv32i_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states, opcodes,
// ALU operation classes and the datapath mux select codes.
package rv32i_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        JAL      = 4'd8,
        ALUWB    = 4'd9,
        BEQ      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RS1   = 2'b10;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core: sequences fetch/decode/execute/
// memory/writeback and drives the datapath selects and strobes.
//
// state    | meaning
// FETCH    | read instruction at PC, PC+4 into PC when memory answers
// DECODE   | compute branch target, dispatch on opcode
// MEMADR   | rs1 + imm for load/store address
// MEMREAD  | load access, wait for mem_ready
// MEMWB    | write read data into rd
// MEMWRITE | store access, wait for mem_ready
// EXECUTER | register-register ALU op
// EXECUTEI | register-immediate ALU op
// JAL      | PC <= target, old PC + 4 into ALU out
// ALUWB    | write ALU out into rd
// BEQ      | compare rs1/rs2, take branch on zero
module multicycle_controller
    import rv32i_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       mem_req_o,
    output logic       adr_src_o,
    output logic       mem_write_o,
    output logic       ir_write_o,
    output logic       pc_write_o,
    output logic       reg_write_o,
    output logic [1:0] result_src_o,
    output logic [1:0] alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] alu_op_o,
    output logic       illegal_op_o,
    output logic       instr_retired_o
);

    state_t state_q, state_d;

    logic mem_req, mem_write, ir_write, pc_update, branch, reg_write;
    logic illegal, retired;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        mem_req      = 1'b0;
        mem_write    = 1'b0;
        ir_write     = 1'b0;
        pc_update    = 1'b0;
        branch       = 1'b0;
        reg_write    = 1'b0;
        illegal      = 1'b0;
        retired      = 1'b0;
        adr_src_o    = 1'b0;
        result_src_o = RES_ALUOUT;
        alu_src_a_o  = SRC_A_PC;
        alu_src_b_o  = SRC_B_RS2;
        alu_op_o     = ALU_ADD;
        unique case (state_q)
            FETCH: begin
                mem_req      = 1'b1;
                alu_src_b_o  = SRC_B_FOUR;
                result_src_o = RES_ALU;
                ir_write     = mem_ready_i;
                pc_update    = mem_ready_i;
                if (mem_ready_i) state_d = DECODE;
            end
            DECODE: begin
                alu_src_a_o = SRC_A_OLDPC;
                alu_src_b_o = SRC_B_IMM;
                case (op_i)
                    OP_LOAD, OP_STORE: state_d = MEMADR;
                    OP_R:              state_d = EXECUTER;
                    OP_I:              state_d = EXECUTEI;
                    OP_JAL:            state_d = JAL;
                    OP_BEQ:            state_d = BEQ;
                    default: begin
                        state_d = FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a_o = SRC_A_RS1;
                alu_src_b_o = SRC_B_IMM;
                state_d     = op_i[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                mem_req   = 1'b1;
                adr_src_o = 1'b1;
                if (mem_ready_i) state_d = MEMWB;
            end
            MEMWB: begin
                result_src_o = RES_RDATA;
                reg_write    = 1'b1;
                retired      = 1'b1;
                state_d      = FETCH;
            end
            MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src_o = 1'b1;
                retired   = mem_ready_i;
                if (mem_ready_i) state_d = FETCH;
            end
            EXECUTER: begin
                alu_src_a_o = SRC_A_RS1;
                alu_op_o    = ALU_FUNCT;
                state_d     = ALUWB;
            end
            EXECUTEI: begin
                alu_src_a_o = SRC_A_RS1;
                alu_src_b_o = SRC_B_IMM;
                alu_op_o    = ALU_FUNCT;
                state_d     = ALUWB;
            end
            JAL: begin
                alu_src_a_o = SRC_A_OLDPC;
                alu_src_b_o = SRC_B_FOUR;
                pc_update   = 1'b1;
                state_d     = ALUWB;
            end
            ALUWB: begin
                reg_write = 1'b1;
                retired   = 1'b1;
                state_d   = FETCH;
            end
            BEQ: begin
                alu_src_a_o = SRC_A_RS1;
                alu_op_o    = ALU_SUB;
                branch      = 1'b1;
                retired     = 1'b1;
                state_d     = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    // State is already FETCH during reset; gating keeps a stale request off the bus.
    assign mem_req_o       = rst_n & mem_req;
    assign mem_write_o     = rst_n & mem_write;
    assign ir_write_o      = rst_n & ir_write;
    assign pc_write_o      = rst_n & (pc_update | (branch & zero_i));
    assign reg_write_o     = rst_n & reg_write;
    assign illegal_op_o    = rst_n & illegal;
    assign instr_retired_o = rst_n & retired;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized and directed checks of multicycle_controller against an
// instruction-level model of cycle-by-cycle control outputs.
module tb_multicycle_controller;

    localparam logic [6:0] T_LOAD  = 7'b0000011;
    localparam logic [6:0] T_STORE = 7'b0100011;
    localparam logic [6:0] T_R     = 7'b0110011;
    localparam logic [6:0] T_I     = 7'b0010011;
    localparam logic [6:0] T_JAL   = 7'b1101111;
    localparam logic [6:0] T_BEQ   = 7'b1100011;

    localparam int K_LOAD = 0, K_STORE = 1, K_R = 2, K_I = 3, K_JAL = 4, K_BEQ = 5, K_ILL = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] op_i = 7'd0;
    logic       zero_i = 1'b0;
    logic       mem_ready_i = 1'b0;
    logic       mem_req_o, adr_src_o, mem_write_o, ir_write_o, pc_write_o, reg_write_o;
    logic [1:0] result_src_o, alu_src_a_o, alu_src_b_o, alu_op_o;
    logic       illegal_op_o, instr_retired_o;

    int errors = 0;
    int checks = 0;

    // model: position within the current instruction (0 = fetch, 1 = decode, ...)
    int step = 0;

    int cnt_cyc, cnt_ret, cnt_ill, cnt_rw, cnt_mw, cnt_pcw, cnt_madr, cnt_sub, ret_at;

    typedef struct packed {
        logic       req, adr, mw, irw, pcw, rw;
        logic [1:0] rs, a, b, alu;
        logic       ill, ret;
    } exp_t;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk(clk), .rst_n(rst_n), .op_i(op_i), .zero_i(zero_i), .mem_ready_i(mem_ready_i),
        .mem_req_o(mem_req_o), .adr_src_o(adr_src_o), .mem_write_o(mem_write_o),
        .ir_write_o(ir_write_o), .pc_write_o(pc_write_o), .reg_write_o(reg_write_o),
        .result_src_o(result_src_o), .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o),
        .alu_op_o(alu_op_o), .illegal_op_o(illegal_op_o), .instr_retired_o(instr_retired_o)
    );

    function automatic int classify(input logic [6:0] o);
        case (o)
            T_LOAD:  return K_LOAD;
            T_STORE: return K_STORE;
            T_R:     return K_R;
            T_I:     return K_I;
            T_JAL:   return K_JAL;
            T_BEQ:   return K_BEQ;
            default: return K_ILL;
        endcase
    endfunction

    function automatic int instr_len(input int k);
        case (k)
            K_LOAD:  return 5;
            K_BEQ:   return 3;
            K_ILL:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit is_wait(input int k, input int s);
        return (s == 0) || ((k == K_LOAD || k == K_STORE) && s == 3);
    endfunction

    // Expected outputs for step s of an instruction of kind k.
    function automatic exp_t model_out(input int k, input int s, input logic r, input logic z);
        exp_t e;
        e = '0;
        if (s == 0) begin
            e.req = 1'b1; e.b = 2'b10; e.rs = 2'b10; e.irw = r; e.pcw = r;
        end else if (s == 1) begin
            e.a = 2'b01; e.b = 2'b01; e.ill = (k == K_ILL);
        end else if (k == K_LOAD || k == K_STORE) begin
            if (s == 2) begin
                e.a = 2'b10; e.b = 2'b01;
            end else if (s == 3) begin
                e.req = 1'b1; e.adr = 1'b1;
                e.mw  = (k == K_STORE);
                e.ret = (k == K_STORE) && r;
            end else begin
                e.rs = 2'b01; e.rw = 1'b1; e.ret = 1'b1;
            end
        end else if (s == 3) begin
            e.rw = 1'b1; e.ret = 1'b1;
        end else begin
            case (k)
                K_R:   begin e.a = 2'b10; e.alu = 2'b10; end
                K_I:   begin e.a = 2'b10; e.b = 2'b01; e.alu = 2'b10; end
                K_JAL: begin e.a = 2'b01; e.b = 2'b10; e.pcw = 1'b1; end
                default: begin e.a = 2'b10; e.alu = 2'b01; e.pcw = z; e.ret = 1'b1; end
            endcase
        end
        return e;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (step %0d, t=%0t)", name, got, exp, step, $time);
        end
    endtask

    // One clock cycle: apply inputs, compare at negedge, advance model at posedge.
    task automatic cyc(input logic [6:0] o, input logic z, input logic r);
        exp_t e;
        int   k;
        op_i = o; zero_i = z; mem_ready_i = r;
        k = (step == 0) ? K_R : classify(o);
        @(negedge clk);
        e = model_out(k, step, r, z);
        check("mem_req",       mem_req_o,       e.req);
        check("adr_src",       adr_src_o,       e.adr);
        check("mem_write",     mem_write_o,     e.mw);
        check("ir_write",      ir_write_o,      e.irw);
        check("pc_write",      pc_write_o,      e.pcw);
        check("reg_write",     reg_write_o,     e.rw);
        check("result_src",    result_src_o,    e.rs);
        check("alu_src_a",     alu_src_a_o,     e.a);
        check("alu_src_b",     alu_src_b_o,     e.b);
        check("alu_op",        alu_op_o,        e.alu);
        check("illegal_op",    illegal_op_o,    e.ill);
        check("instr_retired", instr_retired_o, e.ret);
        cnt_cyc++;
        if (instr_retired_o) begin cnt_ret++; ret_at = cnt_cyc; end
        cnt_ill  += int'(illegal_op_o);
        cnt_rw   += int'(reg_write_o);
        cnt_mw   += int'(mem_write_o);
        cnt_pcw  += int'(pc_write_o);
        cnt_madr += int'(mem_req_o && adr_src_o);
        cnt_sub  += int'(alu_op_o == 2'b01);
        @(posedge clk);
        if (!(is_wait(k, step) && !r)) begin
            step++;
            if (step >= instr_len(k)) step = 0;
        end
        #1;
    endtask

    task automatic run_instr(input logic [6:0] o, input logic z, input int stalls);
        int left;
        left = stalls;
        cnt_cyc = 0; cnt_ret = 0; cnt_ill = 0; cnt_rw = 0; cnt_mw = 0;
        cnt_pcw = 0; cnt_madr = 0; cnt_sub = 0; ret_at = 0;
        for (int i = 0; i < 40; i++) begin
            if (step == 3 && left > 0) begin
                left--;
                cyc(o, z, 1'b0);
            end else begin
                cyc(o, z, 1'b1);
            end
            if (step == 0) break;
        end
        check("instr_timeout", (step == 0) ? 1 : 0, 1);
    endtask

    initial begin
        // reset state
        #2;
        check("rst_mem_req", mem_req_o, 0);
        check("rst_ir_write", ir_write_o, 0);
        check("rst_pc_write", pc_write_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_mem_req", mem_req_o, 1);
        check("post_rst_src_b", alu_src_b_o, 2);
        @(posedge clk); #1;

        // R-type: 4 cycles, retire on last
        run_instr(T_R, 1'b0, 0);
        check("r_cycles", cnt_cyc, 4);
        check("r_ret_at", ret_at, 4);
        check("r_reg_write", cnt_rw, 1);

        // lw with 3 stall cycles in MEMREAD
        run_instr(T_LOAD, 1'b0, 3);
        check("lw_cycles", cnt_cyc, 8);
        check("lw_memread_cycles", cnt_madr, 4);
        check("lw_ret_at", ret_at, 8);
        check("lw_reg_write", cnt_rw, 1);

        // sw
        run_instr(T_STORE, 1'b0, 0);
        check("sw_cycles", cnt_cyc, 4);
        check("sw_mem_write", cnt_mw, 1);
        check("sw_reg_write", cnt_rw, 0);
        check("sw_retired", cnt_ret, 1);

        // beq taken / not taken (fetch contributes one pc_write)
        run_instr(T_BEQ, 1'b1, 0);
        check("beq_t_cycles", cnt_cyc, 3);
        check("beq_t_pc_write", cnt_pcw, 2);
        check("beq_t_sub", cnt_sub, 1);
        run_instr(T_BEQ, 1'b0, 0);
        check("beq_nt_pc_write", cnt_pcw, 1);
        check("beq_nt_sub", cnt_sub, 1);

        run_instr(T_JAL, 1'b0, 0);
        check("jal_cycles", cnt_cyc, 4);
        check("jal_pc_write", cnt_pcw, 2);

        run_instr(7'b0000000, 1'b0, 0);
        check("ill_cycles", cnt_ill == 1 ? cnt_cyc : -1, 2);
        check("ill_pulses", cnt_ill, 1);
        check("ill_retired", cnt_ret, 0);

        // reset during an active fetch request
        cyc(T_LOAD, 1'b0, 1'b0);
        op_i = T_LOAD; mem_ready_i = 1'b0;
        @(negedge clk);
        check("pre_rst_req", mem_req_o, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_req", mem_req_o, 0);
        check("mid_rst_strobes",
              {mem_write_o, ir_write_o, pc_write_o, reg_write_o, illegal_op_o, instr_retired_o}, 0);
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step = 0;
        #1;
        check("rel_mem_req", mem_req_o, 1);
        check("rel_src_b", alu_src_b_o, 2);
        @(posedge clk); #1;

        // randomized instruction stream with random memory stalls
        begin
            logic [6:0] o;
            o = T_R;
            for (int n = 0; n < 3000; n++) begin
                if (step == 0) begin
                    case ($urandom_range(0, 6))
                        0: o = T_LOAD;
                        1: o = T_STORE;
                        2: o = T_R;
                        3: o = T_I;
                        4: o = T_JAL;
                        5: o = T_BEQ;
                        default: o = 7'($urandom);
                    endcase
                end
                cyc(o, 1'($urandom), ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
